// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants, immediate-format encodings and ID-stage state encodings.
// Imported by the decode-stage controller and its hazard detector.
package riscv_pkg;

   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcOpImm = 7'b0010011;
   localparam logic [6:0] OpcLoad  = 7'b0000011;
   localparam logic [6:0] OpcStore = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJal   = 7'b1101111;
   localparam logic [6:0] OpcJalr  = 7'b1100111;
   localparam logic [6:0] OpcLui   = 7'b0110111;
   localparam logic [6:0] OpcAuipc = 7'b0010111;

   // addi x0, x0, 0
   localparam logic [31:0] InstrNop = 32'h0000_0013;

   typedef enum logic [2:0] {
      ImmNone = 3'd0,
      ImmI    = 3'd1,
      ImmS    = 3'd2,
      ImmB    = 3'd3,
      ImmJ    = 3'd4,
      ImmU    = 3'd5
   } imm_sel_e;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StStall = 2'd1,
      StFlush = 2'd2
   } id_state_e;

   function automatic imm_sel_e imm_decode(logic [6:0] opcode);
      imm_sel_e sel;
      case (opcode)
         OpcOpImm, OpcLoad, OpcJalr: sel = ImmI;
         OpcStore:                   sel = ImmS;
         OpcBranch:                  sel = ImmB;
         OpcJal:                     sel = ImmJ;
         OpcLui, OpcAuipc:           sel = ImmU;
         default:                    sel = ImmNone;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: decodes which source registers the held instruction reads and
// compares them against the destination of a load sitting in EX.
module hazard_detect
   import riscv_pkg::*;
(
   input  logic       id_valid_i,
   input  logic [6:0] opcode_i,
   input  logic [4:0] rs1_i,
   input  logic [4:0] rs2_i,
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rd_i,
   output logic       hazard_o
);

   logic use_rs1;
   logic use_rs2;

   always_comb begin
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      case (opcode_i)
         OpcLui, OpcAuipc, OpcJal:    use_rs1 = 1'b0;
         OpcOp, OpcStore, OpcBranch:  use_rs2 = 1'b1;
         default:                     ;
      endcase
   end

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = (ex_rd_i == rs1_i) & use_rs1;
   assign rs2_match = (ex_rd_i == rs2_i) & use_rs2;

   // x0 is never a real dependency, so a load targeting it cannot stall.
   assign hazard_o = id_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) & (rs1_match | rs2_match);

endmodule

// File: rtl/id_pipe_ctrl.sv
// Decode-stage sequencer: owns the IF/ID register, inserts load-use bubbles, discards
// wrong-path fetches after a redirect, and freezes on downstream memory busy.
module id_pipe_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned LOAD_STALL   = 1,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [31:0]      if_instr,
   input  logic [XLEN-1:0]  if_pc,
   output logic             if_ready,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             id_valid,
   output logic [31:0]      id_instr,
   output logic [XLEN-1:0]  id_pc,
   output logic [2:0]       imm_sel,
   output logic [4:0]       id_rs1,
   output logic [4:0]       id_rs2,
   output logic             ex_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   id_state_e        state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [31:0]      instr_q, instr_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             hazard;

   hazard_detect u_hazard_detect (
      .id_valid_i    (valid_q),
      .opcode_i      (instr_q[6:0]),
      .rs1_i         (instr_q[19:15]),
      .rs2_i         (instr_q[24:20]),
      .ex_mem_read_i (ex_mem_read),
      .ex_rd_i       (ex_rd),
      .hazard_o      (hazard)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         cnt_q       <= 3'd0;
         valid_q     <= 1'b0;
         instr_q     <= InstrNop;
         pc_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         valid_q     <= valid_d;
         instr_q     <= instr_d;
         pc_q        <= pc_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      instr_d     = instr_q;
      pc_d        = pc_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (mem_busy) begin
         // Full freeze: EX keeps any pending redirect until the busy window ends.
      end else if (ex_branch_taken) begin
         valid_d     = 1'b0;
         instr_d     = InstrNop;
         flush_cnt_d = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
         cnt_d       = 3'(FLUSH_CYCLES);
         state_d     = (FLUSH_CYCLES == 0) ? StRun : StFlush;
      end else begin
         case (state_q)
            StFlush: begin
               valid_d = 1'b0;
               instr_d = InstrNop;
               cnt_d   = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = StRun;
               end
            end
            StStall: begin
               stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
               cnt_d       = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = StRun;
               end
            end
            default: begin
               if (hazard) begin
                  stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
                  if (LOAD_STALL > 1) begin
                     state_d = StStall;
                     cnt_d   = 3'(LOAD_STALL - 1);
                  end
               end else begin
                  valid_d = if_valid;
                  if (if_valid) begin
                     instr_d = if_instr;
                     pc_d    = if_pc;
                  end else begin
                     instr_d = InstrNop;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      if_ready  = 1'b0;
      ex_bubble = 1'b0;
      if (mem_busy) begin
         if_ready  = 1'b0;
         ex_bubble = 1'b0;
      end else if (ex_branch_taken || (state_q == StFlush)) begin
         if_ready  = 1'b1;
         ex_bubble = 1'b1;
      end else if ((state_q == StStall) || hazard) begin
         if_ready  = 1'b0;
         ex_bubble = 1'b1;
      end else begin
         if_ready  = 1'b1;
         ex_bubble = ~valid_q;
      end
   end

   assign id_valid  = valid_q;
   assign id_instr  = instr_q;
   assign id_pc     = pc_q;
   assign id_rs1    = instr_q[19:15];
   assign id_rs2    = instr_q[24:20];
   assign imm_sel   = valid_q ? imm_decode(instr_q[6:0]) : ImmNone;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
